spi_reg_master: RTL and testbench
=================================

SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCK half-period; legal range 4..255.
REQ-002 SHALL have parameter CS_GAP, default 2: clk cycles spi_cs_n stays high between frames; legal range 1..255.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_write  input  1  1 = register write, 0 = register read.
REQ-008 cmd_addr  input  4  register address.
REQ-009 cmd_wdata  input  8  write data; ignored for reads.
REQ-010 rsp_valid  output  1  one-cycle pulse, transaction complete.
REQ-011 rsp_rdata  output  8  last 8 MISO bits of the completed frame.
REQ-012 spi_cs_n  output  1  chip select, active low.
REQ-013 spi_clk  output  1  SPI clock, mode 0, idle low.
REQ-014 spi_mosi  output  1  serial data to the register slave.
REQ-015 spi_miso  input  1  serial data from the register slave, asynchronous.

Function
REQ-016 Frame SHALL be 16 bits, MSB first: {cmd_write, 3'b000, cmd_addr[3:0], cmd_wdata or 8'h00 on reads}.
REQ-017 Command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; the frame is latched internally then.
REQ-018 FSM states: IDLE, LOW, HIGH, HOLD, GAP; cmd_ready=1 only in IDLE, registered.
REQ-019 IDLE->LOW on accept: spi_cs_n=0, spi_clk=0, spi_mosi=frame bit 15 from the next cycle.
REQ-020 LOW lasts CLK_DIV cycles with spi_clk=0, then ->HIGH; HIGH lasts CLK_DIV cycles with spi_clk=1.
REQ-021 spi_mosi SHALL change only on entry to LOW, to the next frame bit, stable through the following HIGH.
REQ-022 spi_miso SHALL pass a 2-flop synchronizer; the synchronized value is shifted into an 8-bit register on the last cycle of each HIGH.
REQ-023 After the 16th HIGH, ->HOLD: spi_clk=0, spi_cs_n=0 for CLK_DIV cycles; then ->GAP.
REQ-024 spi_cs_n SHALL be low exactly 33*CLK_DIV cycles per frame (132 at default).
REQ-025 On entry to GAP: spi_cs_n=1, rsp_valid=1 for that one cycle, rsp_rdata updated from the MISO shift register.
REQ-026 rsp_rdata SHALL hold its value until the next rsp_valid; it is updated for writes too.
REQ-027 GAP lasts CS_GAP cycles, then ->IDLE; back-to-back frames are therefore separated by CS_GAP+1 cycles of spi_cs_n=1.
REQ-028 cmd_valid while busy SHALL be ignored with no side effect; command inputs may change freely while busy.
REQ-029 spi_mosi SHALL be 0 whenever spi_cs_n=1.
REQ-030 Bit and phase counters SHALL never wrap inside a frame; the bit counter counts 15 down to 0.

Reset
REQ-031 While rst=1 at a rising edge: state=IDLE, cmd_ready=1, spi_cs_n=1, spi_clk=0, spi_mosi=0, rsp_valid=0, rsp_rdata=8'h00, shift registers cleared.
REQ-032 Reset mid-frame SHALL abort the frame with no rsp_valid; outputs reach reset values the cycle after the reset edge.
REQ-033 cmd_valid asserted during rst SHALL not be accepted.

Verification
REQ-034 Write addr 0x3 data 0xA5 -> MOSI shows 16'h83A5 sampled on SCK rising edges, 16 SCK pulses, cs_n low 132 cycles, one rsp_valid.
REQ-035 Read addr 0x7, slave model drives 0x5C in bits 7..0 -> MOSI 16'h0700, rsp_valid pulse with rsp_rdata=0x5C.
REQ-036 cmd_valid held high for two commands -> second accepted exactly CS_GAP cycles after rsp_valid; cs_n high 3 cycles between frames.
REQ-037 rst asserted after 5 SCK pulses -> cs_n=1, spi_clk=0, cmd_ready=1 the next cycle, no rsp_valid; next command runs a full correct frame.
REQ-038 cmd_valid toggled with changing addr while busy -> in-flight frame unchanged, no extra accept.
REQ-039 CLK_DIV=8 run of scenario REQ-035 -> SCK half-period 8 cycles, cs_n low 264 cycles, rsp_rdata=0x5C.

Source files
------------

// File: rtl/spi_reg_master_if.sv
// Command/response bus of the SPI register master.
//   master modport : the requester (drives cmd_*, receives cmd_ready/rsp_*)
//   slave  modport : spi_reg_master itself
//   cmd_valid/cmd_ready : accept handshake, cmd_write/cmd_addr/cmd_wdata : command
//   rsp_valid : one-cycle completion pulse, rsp_rdata : last 8 MISO bits of frame
interface spi_reg_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/spi_reg_master.sv
// SPI (mode 0) register master: sends one 16-bit frame
// {write, 3'b000, addr[3:0], wdata | 8'h00} per command, MSB first, and returns
// the last 8 bits received on MISO.
// Ports:
//   clk, rst  : single clock, synchronous active-high reset
//   bus       : command/response interface (slave modport)
//   spi_cs_n  : chip select, active low
//   spi_clk   : SPI clock, idle low, half-period CLK_DIV clk cycles
//   spi_mosi  : serial data out, 0 whenever spi_cs_n is high
//   spi_miso  : serial data in, asynchronous (synchronized internally)
module spi_reg_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_reg_master_if.slave        bus,
  output logic                   spi_cs_n,
  output logic                   spi_clk,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_HOLD = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  state_t      state_r;
  logic [7:0]  phase_r;      // cycles left in the current state, counts down to 0
  logic [3:0]  bit_r;        // frame bit currently on MOSI, 15 down to 0
  logic [15:0] frame_r;
  logic [7:0]  rx_r;
  logic [1:0]  miso_sync_r;
  logic        cmd_ready_r;
  logic        rsp_valid_r;
  logic [7:0]  rsp_rdata_r;

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;

  // Two-flop synchronizer for the asynchronous MISO line.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_sync_r <= 2'b00;
    end else begin
      miso_sync_r <= {miso_sync_r[0], spi_miso};
    end
  end

  // Frame sequencer; every output is a register updated on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      phase_r     <= 8'd0;
      bit_r       <= 4'd0;
      frame_r     <= 16'h0000;
      rx_r        <= 8'h00;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 8'h00;
      spi_cs_n    <= 1'b1;
      spi_clk     <= 1'b0;
      spi_mosi    <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // cmd_ready_r is 1 throughout IDLE, so cmd_valid alone means accept.
          if (bus.cmd_valid) begin
            frame_r     <= {bus.cmd_write, 3'b000, bus.cmd_addr,
                            (bus.cmd_write ? bus.cmd_wdata : 8'h00)};
            state_r     <= ST_LOW;
            phase_r     <= DIV_LAST;
            bit_r       <= 4'd15;
            cmd_ready_r <= 1'b0;
            spi_cs_n    <= 1'b0;
            spi_clk     <= 1'b0;
            spi_mosi    <= bus.cmd_write;   // frame bit 15
          end
        end
        ST_LOW: begin
          if (phase_r == 8'd0) begin
            state_r <= ST_HIGH;
            phase_r <= DIV_LAST;
            spi_clk <= 1'b1;
          end else begin
            phase_r <= phase_r - 8'd1;
          end
        end
        ST_HIGH: begin
          if (phase_r == 8'd0) begin
            // Sample at the very end of HIGH so the slave had the whole
            // preceding LOW plus HIGH to settle through the synchronizer.
            rx_r    <= {rx_r[6:0], miso_sync_r[1]};
            phase_r <= DIV_LAST;
            spi_clk <= 1'b0;
            if (bit_r == 4'd0) begin
              state_r <= ST_HOLD;
            end else begin
              state_r  <= ST_LOW;
              bit_r    <= bit_r - 4'd1;
              spi_mosi <= frame_r[bit_r - 4'd1];
            end
          end else begin
            phase_r <= phase_r - 8'd1;
          end
        end
        ST_HOLD: begin
          if (phase_r == 8'd0) begin
            state_r     <= ST_GAP;
            phase_r     <= GAP_LAST;
            spi_cs_n    <= 1'b1;
            spi_mosi    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= rx_r;
          end else begin
            phase_r <= phase_r - 8'd1;
          end
        end
        ST_GAP: begin
          if (phase_r == 8'd0) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
          end else begin
            phase_r <= phase_r - 8'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          phase_r     <= 8'd0;
          cmd_ready_r <= 1'b1;
          spi_cs_n    <= 1'b1;
          spi_clk     <= 1'b0;
          spi_mosi    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Self-checking bench for spi_reg_master: two instances (CLK_DIV 4 and 8),
// a passive bus monitor that reconstructs each frame from the pins, and a
// mode-0 slave model that shifts a chosen 16-bit word out on MISO.
module tb_spi_reg_master;
  localparam int CS_GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        = 1'b1;
  logic        sel        = 1'b0;   // 0: CLK_DIV=4 instance, 1: CLK_DIV=8 instance
  logic        cmd_valid  = 1'b0;
  logic        cmd_write  = 1'b0;
  logic [3:0]  cmd_addr   = 4'h0;
  logic [7:0]  cmd_wdata  = 8'h00;
  logic        miso       = 1'b0;
  logic [15:0] slave_word = 16'h0000;

  int n_checks = 0;
  int n_fail   = 0;

  spi_reg_master_if if4 ();
  spi_reg_master_if if8 ();
  logic cs4, sck4, mosi4, cs8, sck8, mosi8;

  assign if4.cmd_valid = cmd_valid & ~sel;
  assign if4.cmd_write = cmd_write;
  assign if4.cmd_addr  = cmd_addr;
  assign if4.cmd_wdata = cmd_wdata;
  assign if8.cmd_valid = cmd_valid & sel;
  assign if8.cmd_write = cmd_write;
  assign if8.cmd_addr  = cmd_addr;
  assign if8.cmd_wdata = cmd_wdata;

  spi_reg_master #(.CLK_DIV(4), .CS_GAP(CS_GAP)) dut4 (
    .clk(clk), .rst(rst), .bus(if4),
    .spi_cs_n(cs4), .spi_clk(sck4), .spi_mosi(mosi4), .spi_miso(miso)
  );
  spi_reg_master #(.CLK_DIV(8), .CS_GAP(CS_GAP)) dut8 (
    .clk(clk), .rst(rst), .bus(if8),
    .spi_cs_n(cs8), .spi_clk(sck8), .spi_mosi(mosi8), .spi_miso(miso)
  );

  wire       cs_m    = sel ? cs8 : cs4;
  wire       sck_m   = sel ? sck8 : sck4;
  wire       mosi_m  = sel ? mosi8 : mosi4;
  wire       rdy_m   = sel ? if8.cmd_ready : if4.cmd_ready;
  wire       rsp_m   = sel ? if8.rsp_valid : if4.rsp_valid;
  wire [7:0] rdata_m = sel ? if8.rsp_rdata : if4.rsp_rdata;

  // ---------------- pin monitor ----------------
  logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
  int          start_cnt = 0, frame_cnt = 0, rsp_cnt = 0;
  int          idle_mosi_bad = 0, mosi_unstable = 0;
  int          hi_cs_run = 0, cur_sck = 0, cur_low = 0, run = 0;
  int          hmin = 0, hmax = 0, lmin = 0, lmax = 0;
  logic [15:0] cur_mosi = 16'h0000;
  logic [15:0] fr_mosi [0:63];
  int          fr_sck [0:63], fr_low [0:63], fr_gap [0:63];
  int          fr_hmin [0:63], fr_hmax [0:63], fr_lmin [0:63], fr_lmax [0:63];

  // Rebuild frames, pulse widths and idle behaviour from the SPI pins.
  always @(negedge clk) begin
    prev_sck  <= sck_m;
    prev_cs   <= cs_m;
    prev_mosi <= mosi_m;
    if (rsp_m) rsp_cnt <= rsp_cnt + 1;
    if (cs_m && mosi_m) idle_mosi_bad <= idle_mosi_bad + 1;
    if (!cs_m && sck_m && prev_sck && (mosi_m !== prev_mosi)) mosi_unstable <= mosi_unstable + 1;
    if (cs_m) begin
      hi_cs_run <= prev_cs ? hi_cs_run + 1 : 1;
      if (!prev_cs && frame_cnt < 64) begin
        fr_mosi[frame_cnt] <= cur_mosi;
        fr_sck[frame_cnt]  <= cur_sck;
        fr_low[frame_cnt]  <= cur_low;
        fr_hmin[frame_cnt] <= hmin;
        fr_hmax[frame_cnt] <= hmax;
        fr_lmin[frame_cnt] <= lmin;
        fr_lmax[frame_cnt] <= lmax;
        frame_cnt          <= frame_cnt + 1;
      end
    end else if (prev_cs) begin
      if (frame_cnt < 64) fr_gap[frame_cnt] <= hi_cs_run;
      start_cnt <= start_cnt + 1;
      cur_low   <= 1;
      cur_sck   <= 0;
      cur_mosi  <= 16'h0000;
      run       <= 1;
      hmin <= 1000; hmax <= 0; lmin <= 1000; lmax <= 0;
    end else begin
      cur_low <= cur_low + 1;
      if (sck_m && !prev_sck) begin
        cur_sck  <= cur_sck + 1;
        cur_mosi <= {cur_mosi[14:0], mosi_m};
        if (run < lmin) lmin <= run;
        if (run > lmax) lmax <= run;
        run <= 1;
      end else if (!sck_m && prev_sck) begin
        if (run < hmin) hmin <= run;
        if (run > hmax) hmax <= run;
        run <= 1;
      end else begin
        run <= run + 1;
      end
    end
  end

  // ---------------- mode-0 slave model ----------------
  logic [3:0] sl_idx   = 4'd0;
  logic       sl_prevk = 1'b0;

  // Present bit 15 while deselected, advance one bit on each SCK falling edge.
  always @(negedge clk) begin
    sl_prevk <= sck_m;
    if (cs_m) begin
      sl_idx <= 4'd0;
      miso   <= slave_word[15];
    end else if (sl_prevk && !sck_m && sl_idx != 4'd15) begin
      sl_idx <= sl_idx + 4'd1;
      miso   <= slave_word[4'd14 - sl_idx];
    end
  end

  // Run one command and compare everything observed with the reference frame.
  task automatic do_frame(input logic w, input logic [3:0] a, input logic [7:0] d,
                          input logic [15:0] mw, input bit noise, input string tag);
    int div, s0, f0, r0, t;
    logic [15:0] exp_frame;
    logic [7:0]  got_rd;
    div       = sel ? 8 : 4;
    exp_frame = {w, 3'b000, a, (w ? d : 8'h00)};
    @(negedge clk);
    slave_word = mw;
    @(negedge clk);
    t = 0;
    while (rdy_m !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    s0 = start_cnt; f0 = frame_cnt; r0 = rsp_cnt;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (rsp_m !== 1'b1 && t < 40 * div) begin
      if (noise) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 4'($urandom);
        cmd_wdata = 8'($urandom);
      end
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b0;
    got_rd = rdata_m;
    n_checks++;
    if (t >= 40 * div) begin n_fail++; $display("FAIL %s rsp_timeout: got none expected rsp_valid", tag); end
    repeat (CS_GAP + 4) @(negedge clk);
    n_checks++;
    if (start_cnt !== s0 + 1) begin n_fail++; $display("FAIL %s frames_started: got %0d expected %0d", tag, start_cnt - s0, 1); end
    n_checks++;
    if (fr_mosi[f0] !== exp_frame) begin n_fail++; $display("FAIL %s mosi_frame: got %h expected %h", tag, fr_mosi[f0], exp_frame); end
    n_checks++;
    if (fr_sck[f0] !== 16) begin n_fail++; $display("FAIL %s sck_pulses: got %0d expected 16", tag, fr_sck[f0]); end
    n_checks++;
    if (fr_low[f0] !== 33 * div) begin n_fail++; $display("FAIL %s cs_low_cycles: got %0d expected %0d", tag, fr_low[f0], 33 * div); end
    n_checks++;
    if (fr_hmin[f0] !== div || fr_hmax[f0] !== div) begin
      n_fail++; $display("FAIL %s sck_high_len: got %0d..%0d expected %0d", tag, fr_hmin[f0], fr_hmax[f0], div);
    end
    n_checks++;
    if (fr_lmin[f0] !== div || fr_lmax[f0] !== div) begin
      n_fail++; $display("FAIL %s sck_low_len: got %0d..%0d expected %0d", tag, fr_lmin[f0], fr_lmax[f0], div);
    end
    n_checks++;
    if (rsp_cnt !== r0 + 1) begin n_fail++; $display("FAIL %s rsp_pulse_cycles: got %0d expected 1", tag, rsp_cnt - r0); end
    n_checks++;
    if (got_rd !== mw[7:0]) begin n_fail++; $display("FAIL %s rsp_rdata: got %h expected %h", tag, got_rd, mw[7:0]); end
    n_checks++;
    if (rdata_m !== mw[7:0]) begin n_fail++; $display("FAIL %s rsp_rdata_hold: got %h expected %h", tag, rdata_m, mw[7:0]); end
    n_checks++;
    if (idle_mosi_bad !== 0 || mosi_unstable !== 0) begin
      n_fail++; $display("FAIL %s mosi_discipline: got idle=%0d unstable=%0d expected 0/0", tag, idle_mosi_bad, mosi_unstable);
    end
  endtask

  task automatic test_reset;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (cs4 !== 1'b1 || if4.cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_hold: got cs_n=%b ready=%b expected 1/1", cs4, if4.cmd_ready);
      end
    end
    n_checks++;
    if ({sck4, mosi4, if4.rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs: got sck/mosi/rsp=%b expected 000", {sck4, mosi4, if4.rsp_valid});
    end
    n_checks++;
    if (if4.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", if4.rsp_rdata); end
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (start_cnt !== 0) begin n_fail++; $display("FAIL reset_no_accept: got %0d frames expected 0", start_cnt); end
  endtask

  task automatic test_write;
    do_frame(1'b1, 4'h3, 8'hA5, 16'h1234, 1'b0, "write_3_a5");
    do_frame(1'b1, 4'hF, 8'hFF, 16'hFF00, 1'b0, "write_f_ff");
  endtask

  task automatic test_read;
    do_frame(1'b0, 4'h7, 8'h00, {8'($urandom), 8'h5C}, 1'b0, "read_7");
    do_frame(1'b0, 4'hF, 8'hFF, 16'h00FF, 1'b0, "read_wdata_ignored");
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      do_frame(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 16'($urandom), 1'b0, "random");
  endtask

  task automatic test_busy_noise;
    do_frame(1'b1, 4'h9, 8'h66, 16'hC3A1, 1'b1, "busy_noise");
  endtask

  task automatic test_back_to_back;
    int f0, t, dt;
    logic [7:0] rd1;
    @(negedge clk);
    slave_word = 16'h00E7;
    t = 0;
    while (rdy_m !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    f0 = frame_cnt;
    cmd_write = 1'b1; cmd_addr = 4'h2; cmd_wdata = 8'h5A; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_write = 1'b0; cmd_addr = 4'hB; cmd_wdata = 8'h77;   // valid stays high
    t = 0;
    while (rsp_m !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    rd1 = rdata_m;
    dt = 0;
    while (cs_m !== 1'b0 && dt < 400) begin @(negedge clk); dt++; end
    cmd_valid = 1'b0;
    n_checks++;
    if (dt !== CS_GAP + 1) begin n_fail++; $display("FAIL b2b_accept_delay: got %0d expected %0d", dt, CS_GAP + 1); end
    t = 0;
    while (rsp_m !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    repeat (CS_GAP + 4) @(negedge clk);
    n_checks++;
    if (fr_mosi[f0] !== 16'h825A) begin n_fail++; $display("FAIL b2b_frame1: got %h expected 825a", fr_mosi[f0]); end
    n_checks++;
    if (fr_mosi[f0 + 1] !== 16'h0B00) begin n_fail++; $display("FAIL b2b_frame2: got %h expected 0b00", fr_mosi[f0 + 1]); end
    n_checks++;
    if (fr_gap[f0 + 1] !== CS_GAP + 1) begin n_fail++; $display("FAIL b2b_cs_high: got %0d expected %0d", fr_gap[f0 + 1], CS_GAP + 1); end
    n_checks++;
    if (rd1 !== 8'hE7 || rdata_m !== 8'hE7) begin n_fail++; $display("FAIL b2b_rdata: got %h/%h expected e7", rd1, rdata_m); end
    n_checks++;
    if (frame_cnt !== f0 + 2) begin n_fail++; $display("FAIL b2b_frames: got %0d expected 2", frame_cnt - f0); end
  endtask

  task automatic test_reset_midframe;
    int r0, t;
    @(negedge clk);
    slave_word = 16'hFFFF;
    t = 0;
    while (rdy_m !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    r0 = rsp_cnt;
    cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 8'hC1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while ((cs_m !== 1'b0 || cur_sck < 5) && t < 1000) begin @(negedge clk); t++; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({cs4, sck4, mosi4, if4.cmd_ready, if4.rsp_valid} !== 5'b10010) begin
      n_fail++; $display("FAIL midreset_outputs: got cs/sck/mosi/rdy/rsp=%b expected 10010",
                         {cs4, sck4, mosi4, if4.cmd_ready, if4.rsp_valid});
    end
    n_checks++;
    if (if4.rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL midreset_rdata: got %h expected 00", if4.rsp_rdata); end
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    n_checks++;
    if (rsp_cnt !== r0 || cs_m !== 1'b1) begin
      n_fail++; $display("FAIL midreset_abort: got rsp=%0d cs_n=%b expected 0/1", rsp_cnt - r0, cs_m);
    end
    do_frame(1'b0, 4'hD, 8'h12, 16'hABCD, 1'b0, "after_reset");
  endtask

  task automatic test_clkdiv8;
    @(negedge clk);
    sel = 1'b1;
    do_frame(1'b0, 4'h7, 8'h00, {8'($urandom), 8'h5C}, 1'b0, "div8_read_7");
    @(negedge clk);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_random();
    test_busy_noise();
    test_back_to_back();
    test_reset_midframe();
    test_clkdiv8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end
endmodule
